// File: rtl/vld_ram_drain.sv
// Read-side drain controller for a valid-tagged page RAM: polls port B in ring order,
// streams valid payloads and clears each entry once accepted. Optional macro: VLD_RAM_DRAIN_CNT_EN.
module vld_ram_drain #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_ADDR_BITS = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [NUM_ADDR_BITS-1:0] addrb,
  output logic                     web,
  output logic [PAYLOAD_BITS:0]    dinb,
  input  logic [PAYLOAD_BITS:0]    doutb,
  output logic [PAYLOAD_BITS-1:0]  dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy
`ifdef VLD_RAM_DRAIN_CNT_EN
  ,
  output logic [31:0]              drain_cnt
`endif
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_CHECK,
    S_HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PAYLOAD_BITS-1:0]   dout_q, dout_d;
  logic                      dout_vld_q, dout_vld_d;
  logic                      accept;

  // The accepted entry is cleared in the same cycle the consumer takes it.
  assign accept   = (state_q == S_HOLD) && dout_rdy;
  assign web      = accept;
  assign addrb    = rd_ptr_q;
  assign dinb     = '0;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    unique case (state_q)
      S_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        // Pointer only advances on acceptance, so an empty slot stalls delivery in order.
        if (doutb[PAYLOAD_BITS]) begin
          dout_d     = doutb[PAYLOAD_BITS-1:0];
          dout_vld_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (dout_rdy) begin
          dout_vld_d = 1'b0;
          rd_ptr_d   = rd_ptr_q + NUM_ADDR_BITS'(1);
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

`ifdef VLD_RAM_DRAIN_CNT_EN
  logic [31:0] drain_cnt_q, drain_cnt_d;

  always_comb begin
    drain_cnt_d = drain_cnt_q;
    if (accept) drain_cnt_d = drain_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drain_cnt_q <= '0;
    else       drain_cnt_q <= drain_cnt_d;
  end

  assign drain_cnt = drain_cnt_q;
`endif

endmodule

// File: doc/vld_ram_drain.md
Name: vld_ram_drain

Overview:
- Read-side controller for the valid-tagged single-port-write page RAM.
- The producer writes {valid=1, payload} through RAM port A.
- This block owns port B. It polls entries in ring order and presents each valid payload on a valid/ready stream.
- When the consumer accepts a payload, the block clears that entry's valid bit through port B so the producer can reuse the slot.

Parameters:
- PAYLOAD_BITS, 32, payload width; RAM words are PAYLOAD_BITS+1 bits wide, with the valid bit at index PAYLOAD_BITS.
- NUM_ADDR_BITS, 7, RAM address width; the ring depth is 2**NUM_ADDR_BITS.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addrb  out  NUM_ADDR_BITS  RAM port-B address; always equals rd_ptr.
- web  out  1  RAM port-B write enable; a one-cycle pulse that clears an entry.
- dinb  out  PAYLOAD_BITS+1  RAM port-B write data; constant all-zero, so valid=0.
- doutb  in  PAYLOAD_BITS+1  RAM registered read data; 1-cycle latency from addrb.
- dout  out  PAYLOAD_BITS  stream payload.
- dout_vld  out  1  stream valid.
- dout_rdy  in  1  stream ready.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: rd_ptr=0, state=WAIT, dout_vld=0, dout=0, web=0. The next state is WAIT.
- Reset does not clear RAM valid bits.
- Reset mid-operation aborts a held word: the word is dropped from the stream but stays valid in the RAM, because no clear has been issued.

State machine, states WAIT, CHECK, HOLD:
- WAIT: one bubble cycle so the registered doutb reflects the current addrb. Always goes to CHECK.
- CHECK, doutb[PAYLOAD_BITS]=0: stay in CHECK and re-sample every cycle. rd_ptr is unchanged, which keeps delivery in order.
- CHECK, doutb[PAYLOAD_BITS]=1: register dout <= doutb[PAYLOAD_BITS-1:0], set dout_vld <= 1, go to HOLD.
- HOLD: dout and dout_vld are stable while dout_rdy=0; the payload must not change.
- HOLD handshake (dout_vld & dout_rdy at an edge):
  - web=1 for exactly that cycle, with addrb equal to the accepted entry.
  - dout_vld <= 0.
  - rd_ptr <= rd_ptr+1, wrapping modulo 2**NUM_ADDR_BITS, so 2**NUM_ADDR_BITS-1 goes to 0.
  - Next state is WAIT.
- web is combinational: web = (state==HOLD) & dout_rdy. It is never asserted in any other state.

Throughput and latency:
- Peak throughput is one word per 3 cycles (WAIT, CHECK, HOLD with ready high).
- Latency from a valid entry present at rd_ptr to dout_vld: 1 cycle after the first CHECK sample that shows valid.

Port collisions and protocol rules:
- Producer port-A write to the same address in the clear cycle: the RAM gives port A priority, so the new write survives.
- Producer protocol rule: never write an entry whose valid bit is set, so the only legal collision is a refill of the slot being cleared.
- Empty ring: the block sits in CHECK indefinitely. No output activity, web=0.
- Full ring: entries are drained strictly in address order starting at rd_ptr.

Optional Feature:
- Macro: VLD_RAM_DRAIN_CNT_EN.
- Defined: adds the output port drain_cnt, out, 32 bits, counting accepted handshakes.
  - Reset value 0.
  - Increments by 1 on each handshake cycle.
  - Wraps from 2^32-1 to 0.
- Undefined: the port and counter logic are absent and all other behaviour is identical.

Test Plan:
- Reset, then RAM all invalid for 50 cycles -> dout_vld=0, web=0, addrb=0 throughout.
- Producer writes addr0=0x11, addr1=0x22, addr2=0x33 (valid); dout_rdy=1 -> dout 0x11, 0x22, 0x33 in order, 3 cycles apart.
  - web pulses once for each word, with addrb=0, 1, 2; afterwards the RAM valid bits at 0..2 read 0.
- Word 0xAB at rd_ptr, with dout_rdy held low for 10 cycles then high -> dout=0xAB stable and dout_vld=1 for 10 cycles.
  - Single web pulse on the accepting cycle; rd_ptr increments by 1.
- Fill all 128 entries (NUM_ADDR_BITS=7) with data 0..127, drain them, then write addr0=0x5A -> outputs 0..127 with rd_ptr wrapping 127->0, then 0x5A.
- Assert reset while in HOLD with word 0x77 at addr5 -> dout_vld=0 next cycle, rd_ptr=0, no web pulse.
  - Then write addr0..4 valid -> those drain; addr5 still reads valid and is delivered (0x77) after them.
- Define VLD_RAM_DRAIN_CNT_EN and drain 5 words -> drain_cnt=5; preload 0xFFFFFFFF plus one handshake -> 0.
